// File: rtl/input_event_capture.sv
// Input event capture: edge detection on deserialized pin samples, coarse/fine
// timestamping relative to the last heartbeat, holdoff gating and a
// first-word-fall-through timestamp FIFO with sticky overflow.
module input_event_capture #(
  parameter int SERDES_WIDTH    = 4,
  parameter int COARSE_WIDTH    = 24,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int HOLDOFF_WIDTH   = 8
) (
  input  logic                                          evrClk,
  input  logic                                          evrRst_n,
  input  logic [SERDES_WIDTH-1:0]                       serdesPattern,
  input  logic                                          evrHBstrobe,
  input  logic                                          captureEnable,
  input  logic                                          risingEdge,
  input  logic [HOLDOFF_WIDTH-1:0]                      holdoff,
  input  logic                                          overflowClear,
  input  logic                                          tsReady,
  output logic                                          tsValid,
  output logic [COARSE_WIDTH+$clog2(SERDES_WIDTH)-1:0]  tsData,
  output logic                                          captureStrobe,
  output logic                                          overflow
);

  localparam int FINE_W = $clog2(SERDES_WIDTH);
  localparam int DATA_W = COARSE_WIDTH + FINE_W;
  localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;

  logic [COARSE_WIDTH-1:0]    coarse_cnt;
  logic [COARSE_WIDTH-1:0]    cur_coarse;
  logic [COARSE_WIDTH-1:0]    next_coarse;
  logic                       prev_bit;
  logic [HOLDOFF_WIDTH-1:0]   hold_cnt;
  logic [SERDES_WIDTH-1:0]    prior;
  logic [SERDES_WIDTH-1:0]    edge_vec;
  logic [FINE_W-1:0]          fine_sel;
  logic                       accept;

  logic                       s1_valid;
  logic [DATA_W-1:0]          s1_data;

  logic [DATA_W-1:0]          mem [DEPTH];
  logic [FIFO_ADDR_WIDTH:0]   wr_ptr;
  logic [FIFO_ADDR_WIDTH:0]   rd_ptr;
  logic                       empty;
  logic                       full;
  logic                       pop;
  logic                       push;
  logic                       drop;
  logic                       ovf;

  // A heartbeat word is timestamp 0; the counter then runs and saturates.
  assign cur_coarse  = evrHBstrobe ? '0 : coarse_cnt;
  assign next_coarse = (&cur_coarse) ? cur_coarse : cur_coarse + COARSE_WIDTH'(1);

  // Each sample is compared against the one just before it in time; bit 0
  // looks back at the last sample of the previous word.
  assign prior    = {serdesPattern[SERDES_WIDTH-2:0], prev_bit};
  assign edge_vec = risingEdge ? (~prior & serdesPattern) : (prior & ~serdesPattern);
  assign accept   = (|edge_vec) && captureEnable && (hold_cnt == '0);

  // Earliest edge in the word wins.
  always_comb begin
    fine_sel = '0;
    for (int i = SERDES_WIDTH - 1; i >= 0; i--) begin
      if (edge_vec[i]) fine_sel = FINE_W'(i);
    end
  end

  // Coarse counter and previous-sample history (history tracks even when disabled).
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      coarse_cnt <= '0;
      prev_bit   <= 1'b0;
    end else begin
      coarse_cnt <= next_coarse;
      prev_bit   <= serdesPattern[SERDES_WIDTH-1];
    end
  end

  // Holdoff dead-time: reload on capture, otherwise count down one per word.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      hold_cnt <= '0;
    end else if (accept) begin
      hold_cnt <= holdoff;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLDOFF_WIDTH'(1);
    end
  end

  // Stage 1 register: accepted capture and its timestamp.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_data <= {cur_coarse, fine_sel};
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                 (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
  assign pop   = !empty && tsReady;
  // A simultaneous pop frees a slot, so a write into a full FIFO still lands.
  assign push  = s1_valid && (!full || pop);
  assign drop  = s1_valid && full && !pop;

  // FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge evrClk) begin
    if (push) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= s1_data;
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (FIFO_ADDR_WIDTH+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (FIFO_ADDR_WIDTH+1)'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (overflowClear) begin
      ovf <= 1'b0;
    end
  end

  assign tsValid       = !empty;
  assign tsData        = empty ? '0 : mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
  assign captureStrobe = s1_valid;
  assign overflow      = ovf;

endmodule

// File: tb/tb_input_event_capture.sv
// Directed bench for input_event_capture: a table of single-word edge cases
// followed by hand-written multi-cycle sequences.
module tb_input_event_capture;

  localparam int W  = 4;
  localparam int CW = 24;
  localparam int AW = 4;
  localparam int HW = 8;
  localparam int DW = CW + 2;

  logic          evrClk = 1'b0;
  logic          evrRst_n;
  logic [W-1:0]  serdesPattern;
  logic          evrHBstrobe;
  logic          captureEnable;
  logic          risingEdge;
  logic [HW-1:0] holdoff;
  logic          overflowClear;
  logic          tsReady;
  logic          tsValid;
  logic [DW-1:0] tsData;
  logic          captureStrobe;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  input_event_capture #(
    .SERDES_WIDTH(W), .COARSE_WIDTH(CW), .FIFO_ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)
  ) dut (
    .evrClk(evrClk), .evrRst_n(evrRst_n), .serdesPattern(serdesPattern),
    .evrHBstrobe(evrHBstrobe), .captureEnable(captureEnable), .risingEdge(risingEdge),
    .holdoff(holdoff), .overflowClear(overflowClear), .tsReady(tsReady),
    .tsValid(tsValid), .tsData(tsData), .captureStrobe(captureStrobe), .overflow(overflow)
  );

  always #5 evrClk = ~evrClk;

  typedef struct {
    logic [3:0] prev;
    logic [3:0] word;
    logic       rise;
    logic       exp_cap;
    logic [1:0] exp_fine;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge evrClk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ts(input int coarse, input int fine);
    logic [CW-1:0] c;
    logic [1:0]    f;
    c = CW'(coarse);
    f = 2'(fine);
    return {c, f};
  endfunction

  int pops;

  initial begin
    // prev, word, rise, capture?, fine   (strings are MSB..LSB, bit 0 earliest)
    vecs[0] = '{4'b0000, 4'b1100, 1'b1, 1'b1, 2'd2};
    vecs[1] = '{4'b1000, 4'b0000, 1'b0, 1'b1, 2'd0};  // cross-word falling edge
    vecs[2] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0};  // last sample of prev is 0
    vecs[3] = '{4'b0000, 4'b1010, 1'b1, 1'b1, 2'd1};  // two edges, first only
    vecs[4] = '{4'b1111, 4'b0111, 1'b0, 1'b1, 2'd3};
    vecs[5] = '{4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0};
    vecs[6] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0};
    vecs[7] = '{4'b0111, 4'b1111, 1'b1, 1'b1, 2'd0};  // cross-word rising edge
    vecs[8] = '{4'b0000, 4'b1100, 1'b0, 1'b0, 2'd0};  // rising only, falling selected
    vecs[9] = '{4'b1000, 4'b0101, 1'b1, 1'b1, 2'd2};

    evrRst_n = 1'b0; serdesPattern = '0; evrHBstrobe = 1'b0; captureEnable = 1'b0;
    risingEdge = 1'b1; holdoff = '0; overflowClear = 1'b0; tsReady = 1'b0;
    #12;
    check("reset_tsValid", tsValid, 0);
    check("reset_tsData", tsData, 0);
    check("reset_strobe", captureStrobe, 0);
    check("reset_overflow", overflow, 0);
    @(posedge evrClk); #1;
    evrRst_n = 1'b1;

    // Heartbeat in cycle 0, rising edge at bit 2 in cycle 5.
    serdesPattern = 4'b0000; evrHBstrobe = 1'b1; captureEnable = 1'b1; tick();
    evrHBstrobe = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    serdesPattern = 4'b1100; tick();
    check("t1_strobe", captureStrobe, 1);
    check("t1_valid_early", tsValid, 0);
    serdesPattern = 4'b0000; tick();
    check("t1_strobe_single", captureStrobe, 0);
    check("t1_valid", tsValid, 1);
    check("t1_data", tsData, ts(5, 2));
    tsReady = 1'b1; tick(); tsReady = 1'b0;
    check("t1_drained", tsValid, 0);

    // Table of single-word edge cases; the heartbeat on the prior word makes coarse 1.
    for (int v = 0; v < 10; v++) begin
      risingEdge = vecs[v].rise;
      serdesPattern = vecs[v].prev; evrHBstrobe = 1'b1; captureEnable = 1'b0; tick();
      serdesPattern = vecs[v].word; evrHBstrobe = 1'b0; captureEnable = 1'b1; tick();
      check($sformatf("vec%0d_strobe", v), captureStrobe, vecs[v].exp_cap);
      captureEnable = 1'b0; tick();
      check($sformatf("vec%0d_valid", v), tsValid, vecs[v].exp_cap);
      if (vecs[v].exp_cap) check($sformatf("vec%0d_data", v), tsData, ts(1, vecs[v].exp_fine));
      tsReady = 1'b1; tick(); tsReady = 1'b0;
      check($sformatf("vec%0d_single", v), tsValid, 0);
    end

    // Holdoff of 3 with an edge candidate every word.
    risingEdge = 1'b1; holdoff = 8'd3; serdesPattern = 4'b0000; captureEnable = 1'b1; tick();
    for (int w = 0; w < 10; w++) begin
      serdesPattern = (w % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      check($sformatf("hold_w%0d", w), captureStrobe, (w == 0 || w == 4 || w == 8));
    end
    captureEnable = 1'b0; serdesPattern = 4'b0000; holdoff = '0; tsReady = 1'b1;
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      if (tsValid) pops++;
      tick();
    end
    tsReady = 1'b0;
    check("hold_entries", pops, 3);

    // Enabling while the input sits high must not create an edge.
    serdesPattern = 4'b1111; tick(); tick();
    captureEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("steady_nocap%0d", i), captureStrobe, 0);
    end
    serdesPattern = 4'b0000; evrHBstrobe = 1'b1; tick();
    check("steady_nocap_low", captureStrobe, 0);
    serdesPattern = 4'b0001; evrHBstrobe = 1'b0; tick();
    check("steady_cap", captureStrobe, 1);
    captureEnable = 1'b0; tick();
    check("steady_data", tsData, ts(1, 0));
    tsReady = 1'b1; tick(); tsReady = 1'b0;

    // Fill past capacity with the consumer stalled: 17 captures, coarse 0..16.
    captureEnable = 1'b1; serdesPattern = 4'b0001;
    for (int k = 0; k <= 16; k++) begin
      evrHBstrobe = (k == 0);
      tick();
    end
    evrHBstrobe = 1'b0;
    check("ovf_strobe17", captureStrobe, 1);
    check("ovf_not_yet", overflow, 0);
    captureEnable = 1'b0; tick();
    check("ovf_set", overflow, 1);
    tsReady = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d_valid", k), tsValid, 1);
      check($sformatf("drain%0d_data", k), tsData, ts(k, 0));
      tick();
    end
    tsReady = 1'b0;
    check("drain_empty", tsValid, 0);
    check("ovf_sticky", overflow, 1);
    overflowClear = 1'b1; tick(); overflowClear = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Reset with three entries queued.
    serdesPattern = 4'b0000; tick();
    captureEnable = 1'b1; serdesPattern = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    captureEnable = 1'b0; tick(); tick();
    check("rst_pre_valid", tsValid, 1);
    evrRst_n = 1'b0; #1;
    check("rst_async_valid", tsValid, 0);
    check("rst_async_data", tsData, 0);
    @(posedge evrClk); #1;
    evrRst_n = 1'b1;
    captureEnable = 1'b1; serdesPattern = 4'b0001; tick();
    check("rst_post_strobe", captureStrobe, 1);
    captureEnable = 1'b0; tick();
    check("rst_post_valid", tsValid, 1);
    check("rst_post_data", tsData, ts(0, 0));
    tsReady = 1'b1; tick(); tsReady = 1'b0;
    check("rst_no_stale", tsValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
